// File: rtl/booth_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : booth_pkg
//  Description : Shared constants for the radix-8 Booth multiplier slice.
//                FSM state encodings, Booth digit select codes
//                (sel[3] = negate, sel[2:0] = magnitude multiple of a) and
//                a helper giving the number of radix-8 digits for a width.
//  Revision    : 1.0  initial release
// ============================================================================
package booth_pkg;

  // FSM state encodings
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_PRE  = 2'd1;
  localparam state_t ST_RUN  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Booth digit select: {negate, magnitude[2:0]}
  localparam logic [3:0] SEL_ZERO = 4'b0000;
  localparam logic [3:0] SEL_P1   = 4'b0001;
  localparam logic [3:0] SEL_P2   = 4'b0010;
  localparam logic [3:0] SEL_P3   = 4'b0011;
  localparam logic [3:0] SEL_P4   = 4'b0100;
  localparam logic [3:0] SEL_N1   = 4'b1001;
  localparam logic [3:0] SEL_N2   = 4'b1010;
  localparam logic [3:0] SEL_N3   = 4'b1011;
  localparam logic [3:0] SEL_N4   = 4'b1100;

  // Number of radix-8 digits needed to cover a multiplier of width bw
  function automatic int ndig(input int bw);
    return (bw + 2) / 3;
  endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r8_pp.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r8_pp
//  Description : Radix-8 Booth digit encoder and partial-product magnitude
//                mux. Purely combinational.
//  Ports       : window [3:0]  multiplier bits {3d+2 .. 3d-1}
//                a             multiplicand, signed
//                a3            precomputed 3*a, signed
//                pp            selected multiple 0/a/2a/3a/4a, signed
//                neg           digit is negative; the caller inverts pp and
//                              injects a carry-in of 1
//  Revision    : 1.0  initial release
// ============================================================================
module booth_r8_pp
  import booth_pkg::*;
#(
  parameter int A_W = 9
) (
  input  logic [3:0]            window,
  input  logic signed [A_W-1:0] a,
  input  logic signed [A_W+1:0] a3,
  output logic signed [A_W+1:0] pp,
  output logic                  neg
);

  localparam int PP_W = A_W + 2;

  logic [3:0]             w_sel;
  logic signed [PP_W-1:0] w_a_ext;

  assign w_a_ext = PP_W'(a);

  always_comb begin
    w_sel = SEL_ZERO;
    case (window)
      4'b0000, 4'b1111: w_sel = SEL_ZERO;
      4'b0001, 4'b0010: w_sel = SEL_P1;
      4'b0011, 4'b0100: w_sel = SEL_P2;
      4'b0101, 4'b0110: w_sel = SEL_P3;
      4'b0111:          w_sel = SEL_P4;
      4'b1000:          w_sel = SEL_N4;
      4'b1001, 4'b1010: w_sel = SEL_N3;
      4'b1011, 4'b1100: w_sel = SEL_N2;
      4'b1101, 4'b1110: w_sel = SEL_N1;
      default:          w_sel = SEL_ZERO;
    endcase
  end

  always_comb begin
    pp = '0;
    case (w_sel[2:0])
      3'd1:    pp = w_a_ext;
      3'd2:    pp = w_a_ext <<< 1;
      3'd3:    pp = a3;
      3'd4:    pp = w_a_ext <<< 2;
      default: pp = '0;
    endcase
  end

  assign neg = w_sel[3];

endmodule
`default_nettype wire

// File: rtl/booth_r8_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : booth_r8_mul_seq
//  Description : Sequential radix-8 Booth multiplier for the brightness path.
//                Scales a pixel by a signed fixed-point gain, one Booth digit
//                per cycle through a single shared adder, then shifts out the
//                gain fraction and clamps to the unsigned pixel range.
//  Ports       : clk, rst_n          clock, async active-low reset
//                in_valid/in_ready   operand handshake (a_in, b_in)
//                out_valid/out_ready result handshake
//                p_out               full signed product a_in*b_in
//                pix_out             clamp(p_out >>> FRAC_W, 0, 2^(A_W-1)-1)
//                sat_flag            pix_out was clamped
//                busy                not idle
//  Revision    : 1.0  initial release
// ============================================================================
module booth_r8_mul_seq
  import booth_pkg::*;
#(
  parameter int A_W    = 9,
  parameter int B_W    = 8,
  parameter int FRAC_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_W-1:0]     a_in,
  input  logic [B_W-1:0]     b_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [A_W+B_W-1:0] p_out,
  output logic [A_W-2:0]     pix_out,
  output logic               sat_flag,
  output logic               busy
);

  localparam int NDIG  = ndig(B_W);
  localparam int BX_W  = 3 * NDIG + 1;     // sign-extended b plus appended b[-1]
  localparam int BXM_W = BX_W - 1;
  localparam int ACC_W = A_W + 3 * NDIG + 1;
  localparam int P_W   = A_W + B_W;
  localparam int PP_W  = A_W + 2;
  localparam int PIX_W = A_W - 1;
  localparam int DIG_W = $clog2(NDIG + 1);

  localparam logic [DIG_W-1:0]        DIG_LAST = DIG_W'(NDIG - 1);
  localparam logic signed [ACC_W-1:0] PIX_MAX  = ACC_W'((1 << PIX_W) - 1);

  state_t                  r_state;
  logic signed [A_W-1:0]   r_a;
  logic signed [PP_W-1:0]  r_a3;
  logic [BX_W-1:0]         r_b_ext;
  logic [DIG_W-1:0]        r_dig;
  logic signed [ACC_W-1:0] r_acc;
  logic [P_W-1:0]          r_p_out;
  logic [PIX_W-1:0]        r_pix;
  logic                    r_sat;

  logic [3:0]              w_win;
  logic signed [PP_W-1:0]  w_pp;
  logic                    w_neg;
  logic signed [ACC_W-1:0] w_acc_next;
  logic signed [ACC_W-1:0] w_shift;
  logic                    w_lo;
  logic                    w_hi;
  logic [PIX_W-1:0]        w_pix;

  // Four-bit Booth window for the current digit; the appended zero at bit 0
  // of r_b_ext lines index 3d up with multiplier bit 3d-1.
  assign w_win = 4'(r_b_ext >> (3 * r_dig));

  booth_r8_pp #(
    .A_W (A_W)
  ) u_pp (
    .window (w_win),
    .a      (r_a),
    .a3     (r_a3),
    .pp     (w_pp),
    .neg    (w_neg)
  );

  // Shared adder: Horner step, MSB digit first. Negative digits are formed
  // as ~pp + 1 with the +1 entering as the carry-in.
  assign w_acc_next = (r_acc <<< 3)
                    + ((ACC_W'(w_pp)) ^ {ACC_W{w_neg}})
                    + ACC_W'(w_neg);

  // Drop the gain fraction (floor) and clamp to the unsigned pixel range.
  // Evaluated on the full accumulator so no product can alias.
  assign w_shift = w_acc_next >>> FRAC_W;
  assign w_lo    = (w_shift < 0);
  assign w_hi    = (w_shift > PIX_MAX);
  assign w_pix   = w_lo ? '0 : (w_hi ? {PIX_W{1'b1}} : w_shift[PIX_W-1:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_a     <= '0;
      r_a3    <= '0;
      r_b_ext <= '0;
      r_dig   <= '0;
      r_acc   <= '0;
      r_p_out <= '0;
      r_pix   <= '0;
      r_sat   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= $signed(a_in);
            r_b_ext <= {BXM_W'($signed(b_in)), 1'b0};
            r_acc   <= '0;
            r_dig   <= DIG_LAST;
            r_state <= ST_PRE;
          end
        end
        ST_PRE: begin
          r_a3    <= PP_W'(r_a) + (PP_W'(r_a) <<< 1);
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          r_acc <= w_acc_next;
          if (r_dig == '0) begin
            // Truncation to P_W is exact: |a*b| always fits the product width.
            r_p_out <= w_acc_next[P_W-1:0];
            r_pix   <= w_pix;
            r_sat   <= w_lo | w_hi;
            r_state <= ST_DONE;
          end else begin
            r_dig <= r_dig - 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign p_out     = r_p_out;
  assign pix_out   = r_pix;
  assign sat_flag  = r_sat;

endmodule
`default_nettype wire

// File: tb/tb_booth_r8_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_booth_r8_mul_seq
//  Description : Self-checking bench for booth_r8_mul_seq. Expected values
//                come from plain integer multiply, floor shift and clamp.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_booth_r8_mul_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  a_in;
  logic [7:0]  b_in;
  logic        out_valid;
  logic        out_ready;
  logic [16:0] p_out;
  logic [7:0]  pix_out;
  logic        sat_flag;
  logic        busy;

  int test_cnt = 0;
  int fail_cnt = 0;

  always #5 clk = ~clk;

  booth_r8_mul_seq #(
    .A_W    (9),
    .B_W    (8),
    .FRAC_W (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a_in      (a_in),
    .b_in      (b_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p_out     (p_out),
    .pix_out   (pix_out),
    .sat_flag  (sat_flag),
    .busy      (busy)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    test_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction. stall > 0 holds out_ready low for that many
  // cycles in DONE while pulsing in_valid with junk operands.
  task automatic run_op(input logic [8:0] a, input logic [7:0] b, input int stall);
    int av, bv, prod, sh, exp_pix, exp_sat, edges, waited;
    logic [16:0] exp_p;
    av      = int'($signed(a));
    bv      = int'($signed(b));
    prod    = av * bv;
    sh      = prod >>> 4;
    exp_pix = (sh < 0) ? 0 : ((sh > 255) ? 255 : sh);
    exp_sat = ((sh < 0) || (sh > 255)) ? 1 : 0;
    exp_p   = 17'(prod);

    waited = 0;
    while (!in_ready && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    check("ready_before_accept", 32'(in_ready), 32'd1);

    @(negedge clk);
    in_valid  = 1'b1;
    a_in      = a;
    b_in      = b;
    out_ready = (stall == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    edges    = 1;                       // the accepting edge is edge 1
    check("busy_after_accept", {30'd0, busy, in_ready}, 32'b10);

    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
    check("latency_edges", 32'(edges), 32'd5);
    check("p_out", 32'(p_out), 32'(exp_p));
    check("pix_out", 32'(pix_out), 32'(exp_pix));
    check("sat_flag", 32'(sat_flag), 32'(exp_sat));

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      a_in     = 9'($urandom);
      b_in     = 8'($urandom);
      @(posedge clk); #1;
      check("stall_hold", {13'd0, out_valid, in_ready, p_out}, {13'd0, 1'b1, 1'b0, exp_p});
    end

    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("after_handshake", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    int seen;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    a_in      = '0;
    b_in      = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ctrl", {28'd0, in_ready, out_valid, busy, sat_flag}, 32'b1000);
    check("reset_data", {7'd0, p_out, pix_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed operand pairs
    run_op(9'd200, 8'h18, 0);   // 1.5 gain, saturates high
    run_op(9'd200, 8'h08, 0);   // 0.5 gain
    run_op(9'd255, 8'h80, 0);   // -8.0 gain, clamps to 0
    run_op(9'd100, 8'h20, 0);   // middle digit is -4a
    run_op(9'd0,   8'h55, 0);
    run_op(9'd55,  8'h00, 0);
    run_op(9'd1,   8'h01, 0);
    run_op(9'h100, 8'h80, 0);   // most negative times most negative
    run_op(9'h0FF, 8'h7F, 0);

    // Output stall with ignored in_valid pulses
    run_op(9'd77, 8'h13, 3);

    // Randomized pairs against the integer reference
    for (int i = 0; i < 1000; i++) begin
      run_op(9'($urandom), 8'($urandom), 0);
    end

    // Reset while in RUN aborts the operation
    @(negedge clk);
    in_valid = 1'b1;
    a_in     = 9'd123;
    b_in     = 8'h33;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_reset_ctrl", {29'd0, in_ready, out_valid, busy}, 32'b100);
    check("abort_reset_data", {7'd0, p_out, pix_out}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("abort_no_valid", 32'(seen), 32'd0);
    run_op(9'd10, 8'h10, 0);

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
`default_nettype wire
